// File: rtl/dac_share_sched.sv
// dac_share_sched: shares one SPI DAC serializer between two strobed sample
// sources. Each channel buffers one sample, and the serializer is granted
// round-robin. The block drives the serializer data/load, adds a channel-select
// bit, and keeps sticky overrun flags plus a saturating overrun count.
module dac_share_sched #(
  parameter int DW          = 10,
  parameter int BUSY_CYCLES = 1000,
  parameter int CW          = 11
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          strobe_a,
  input  logic [DW-1:0] data_a,
  input  logic          strobe_b,
  input  logic [DW-1:0] data_b,
  input  logic          en_b,
  input  logic          ovr_clr,
  output logic [DW-1:0] dac_data,
  output logic          dac_ch,
  output logic          dac_load,
  output logic          busy,
  output logic          ovr_a,
  output logic          ovr_b,
  output logic [7:0]    ovr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BUSY
  } state_t;

  localparam logic [CW-1:0] BUSY_M1 = CW'(BUSY_CYCLES - 1);
  localparam logic          CH_A    = 1'b0;
  localparam logic          CH_B    = 1'b1;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] hold_a_q, hold_a_d;
  logic [DW-1:0] hold_b_q, hold_b_d;
  logic          pend_a_q, pend_a_d;
  logic          pend_b_q, pend_b_d;
  logic          last_q, last_d;
  logic [DW-1:0] dac_data_q, dac_data_d;
  logic          dac_ch_q, dac_ch_d;
  logic          dac_load_q, dac_load_d;
  logic          busy_q, busy_d;
  logic          ovr_a_q, ovr_a_d;
  logic          ovr_b_q, ovr_b_d;
  logic [7:0]    ovr_cnt_q, ovr_cnt_d;

  logic          pend_b_eff;
  logic          grant_a, grant_b;
  logic          ovr_ev_a, ovr_ev_b;
  logic [7:0]    cnt_base;
  logic [8:0]    cnt_sum;

  // Arbitration, transfer sequencing, sample buffering and overrun tracking.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hold_a_d   = hold_a_q;
    hold_b_d   = hold_b_q;
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    last_d     = last_q;
    dac_data_d = dac_data_q;
    dac_ch_d   = dac_ch_q;
    dac_load_d = 1'b0;
    busy_d     = busy_q;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    pend_b_eff = pend_b_q & en_b;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_a_q && pend_b_eff) begin
          grant_a = (last_q == CH_B);
          grant_b = (last_q == CH_A);
        end else begin
          grant_a = pend_a_q;
          grant_b = pend_b_eff;
        end
        if (grant_a || grant_b) begin
          state_d    = ST_LOAD;
          busy_d     = 1'b1;
          count_d    = BUSY_M1;
          dac_data_d = grant_a ? hold_a_q : hold_b_q;
          dac_ch_d   = grant_b;
          last_d     = grant_b;
        end
      end
      ST_LOAD: begin
        dac_load_d = 1'b1;
        state_d    = ST_BUSY;
      end
      ST_BUSY: begin
        if (count_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A grant consumes the old hold value before a same-cycle strobe refills it,
    // so a strobe landing on its own channel's grant is not an overrun.
    ovr_ev_a = strobe_a & pend_a_q & ~grant_a;
    if (grant_a) pend_a_d = 1'b0;
    if (strobe_a) begin
      hold_a_d = data_a;
      pend_a_d = 1'b1;
    end

    ovr_ev_b = en_b & strobe_b & pend_b_q & ~grant_b;
    if (grant_b) pend_b_d = 1'b0;
    if (en_b && strobe_b) begin
      hold_b_d = data_b;
      pend_b_d = 1'b1;
    end
    if (!en_b) pend_b_d = 1'b0;

    // Clear first, then add this cycle's overruns so a coincident overrun wins.
    cnt_base  = ovr_clr ? 8'd0 : ovr_cnt_q;
    cnt_sum   = {1'b0, cnt_base} + {8'd0, ovr_ev_a} + {8'd0, ovr_ev_b};
    ovr_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    ovr_a_d   = (ovr_a_q & ~ovr_clr) | ovr_ev_a;
    ovr_b_d   = (ovr_b_q & ~ovr_clr) | ovr_ev_b;
  end

  // State and output registers; reset leaves B as last grant so A wins the first tie.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      last_q     <= CH_B;
      dac_data_q <= '0;
      dac_ch_q   <= 1'b0;
      dac_load_q <= 1'b0;
      busy_q     <= 1'b0;
      ovr_a_q    <= 1'b0;
      ovr_b_q    <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      last_q     <= last_d;
      dac_data_q <= dac_data_d;
      dac_ch_q   <= dac_ch_d;
      dac_load_q <= dac_load_d;
      busy_q     <= busy_d;
      ovr_a_q    <= ovr_a_d;
      ovr_b_q    <= ovr_b_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign dac_data = dac_data_q;
  assign dac_ch   = dac_ch_q;
  assign dac_load = dac_load_q;
  assign busy     = busy_q;
  assign ovr_a    = ovr_a_q;
  assign ovr_b    = ovr_b_q;
  assign ovr_cnt  = ovr_cnt_q;

endmodule

// File: tb/tb_dac_share_sched.sv
// Testbench for dac_share_sched with a short busy window. A timing-level
// reference model (grant edge, busy window, free edge) predicts every output
// after each clock edge.
module tb_dac_share_sched;

  localparam int DW = 10;
  localparam int BC = 4;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          strobe_a, strobe_b, en_b, ovr_clr;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] dac_data;
  logic          dac_ch, dac_load, busy, ovr_a, ovr_b;
  logic [7:0]    ovr_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int            k;
  int            gl;
  int            free_edge;
  logic [DW-1:0] m_hold_a, m_hold_b;
  bit            m_pa, m_pb;
  int            m_last;
  logic [DW-1:0] m_data;
  bit            m_ch;
  bit            m_oa, m_ob;
  int            m_cnt;
  int            load_b_seen;

  dac_share_sched #(.DW(DW), .BUSY_CYCLES(BC), .CW(CW)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .strobe_a (strobe_a),
    .data_a   (data_a),
    .strobe_b (strobe_b),
    .data_b   (data_b),
    .en_b     (en_b),
    .ovr_clr  (ovr_clr),
    .dac_data (dac_data),
    .dac_ch   (dac_ch),
    .dac_load (dac_load),
    .busy     (busy),
    .ovr_a    (ovr_a),
    .ovr_b    (ovr_b),
    .ovr_cnt  (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    gl = -1000; free_edge = 0;
    m_hold_a = '0; m_hold_b = '0; m_pa = 0; m_pb = 0;
    m_last = 1; m_data = '0; m_ch = 0;
    m_oa = 0; m_ob = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit sa, input logic [DW-1:0] da, input bit sb,
                            input logic [DW-1:0] db, input bit enb, input bit clr);
    bit pb_eff, g, gch, ova, ovb;
    pb_eff = m_pb && enb;
    g   = (k >= free_edge) && (m_pa || pb_eff);
    gch = 0;
    if (g) gch = (m_pa && pb_eff) ? (m_last == 0) : !m_pa;
    ova = sa && m_pa && !(g && gch == 0);
    ovb = enb && sb && m_pb && !(g && gch == 1);
    if (g) begin
      m_data = gch ? m_hold_b : m_hold_a;
      m_ch   = gch;
      if (gch) m_pb = 0; else m_pa = 0;
      m_last = gch;
      gl = k;
      free_edge = k + BC + 2;
    end
    if (sa) begin m_hold_a = da; m_pa = 1; end
    if (enb && sb) begin m_hold_b = db; m_pb = 1; end
    if (!enb) m_pb = 0;
    if (clr) begin m_cnt = 0; m_oa = 0; m_ob = 0; end
    m_cnt = m_cnt + int'(ova) + int'(ovb);
    if (m_cnt > 255) m_cnt = 255;
    m_oa = m_oa | ova;
    m_ob = m_ob | ovb;
  endtask

  task automatic check_all();
    chk("dac_load", 32'(dac_load), 32'(k == gl + 1));
    chk("busy",     32'(busy),     32'(k >= gl && k <= gl + BC));
    chk("dac_data", 32'(dac_data), 32'(m_data));
    chk("dac_ch",   32'(dac_ch),   32'(m_ch));
    chk("ovr_a",    32'(ovr_a),    32'(m_oa));
    chk("ovr_b",    32'(ovr_b),    32'(m_ob));
    chk("ovr_cnt",  32'(ovr_cnt),  32'(m_cnt));
    if (dac_load === 1'b1 && dac_ch === 1'b1) load_b_seen++;
  endtask

  task automatic step(input bit sa, input logic [DW-1:0] da, input bit sb,
                      input logic [DW-1:0] db, input bit enb, input bit clr);
    @(negedge clk);
    strobe_a = sa; data_a = da; strobe_b = sb; data_b = db; en_b = enb; ovr_clr = clr;
    @(posedge clk);
    k++;
    model_edge(sa, da, sb, db, enb, clr);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 1, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_dac_data", 32'(dac_data), 32'd0);
    chk("rst_dac_ch",   32'(dac_ch),   32'd0);
    chk("rst_dac_load", 32'(dac_load), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_ovr_a",    32'(ovr_a),    32'd0);
    chk("rst_ovr_b",    32'(ovr_b),    32'd0);
    chk("rst_ovr_cnt",  32'(ovr_cnt),  32'd0);
  endtask

  initial begin
    reset = 1'b1; strobe_a = 0; strobe_b = 0; en_b = 1; ovr_clr = 0;
    data_a = '0; data_b = '0;
    k = 0; load_b_seen = 0;
    model_reset();
    #12;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Single A sample after an idle stretch: load two edges later.
    idle(9);
    step(1, 10'h155, 0, '0, 1, 0);
    idle(10);

    // Tie with last=B: A first, then B. Then a lone A makes last=A, so the next tie goes to B.
    step(1, 10'h100, 1, 10'h200, 1, 0);
    idle(16);
    step(1, 10'h0AA, 0, '0, 1, 0);
    idle(8);
    step(1, 10'h100, 1, 10'h200, 1, 0);
    idle(16);

    // Three A strobes at relative edges 0, 2, 3: middle sample overwritten.
    step(1, 10'h001, 0, '0, 1, 0);
    idle(1);
    step(1, 10'h002, 0, '0, 1, 0);
    step(1, 10'h003, 0, '0, 1, 0);
    idle(12);
    chk("ovr_a_after_overwrite", 32'(ovr_a), 32'd1);
    step(0, '0, 0, '0, 1, 1);

    // A strobe landing on A's own grant edge: no overrun, reloaded BC+2 later.
    step(1, 10'h011, 0, '0, 1, 0);
    step(1, 10'h022, 0, '0, 1, 0);
    idle(14);

    // B disabled with strobes on both channels: A overruns saturate the count.
    load_b_seen = 0;
    for (int i = 0; i < 400; i++)
      step(1, 10'($urandom), 1'($urandom), 10'($urandom), 0, 0);
    chk("ovr_cnt_saturated", 32'(ovr_cnt), 32'd255);
    chk("no_b_load_when_disabled", 32'(load_b_seen), 32'd0);
    idle(8);
    step(0, '0, 0, '0, 1, 1);
    chk("ovr_cnt_cleared", 32'(ovr_cnt), 32'd0);

    // Clear coinciding with overruns on both channels: count restarts at 2.
    step(1, 10'h031, 1, 10'h032, 1, 0);
    step(1, 10'h041, 1, 10'h042, 1, 0);
    step(1, 10'h051, 1, 10'h052, 1, 1);
    idle(20);

    // Reset while busy with B pending: outputs clear at once, no load afterwards.
    step(1, 10'h0F0, 1, 10'h0F1, 1, 0);
    idle(3);
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(12);

    // Randomized traffic with occasional enable drops and clears.
    for (int i = 0; i < 600; i++) begin
      bit enb;
      enb = ($urandom_range(0, 9) != 0);
      step($urandom_range(0, 5) == 0, 10'($urandom), $urandom_range(0, 5) == 0,
           10'($urandom), enb, $urandom_range(0, 49) == 0);
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
